// File: rtl/ahbl_sram_bridge.sv
// rtl/ahbl_sram_bridge.sv - AHB-Lite slave for a single-port synchronous SRAM
// One-entry posted write buffer with read forwarding; only reads can stall the bus.
module ahbl_sram_bridge #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int HADDR_W = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               hsel,
  input  logic [HADDR_W-1:0] haddr,
  input  logic [1:0]         htrans,
  input  logic               hwrite,
  input  logic [2:0]         hsize,
  input  logic [DATA_W-1:0]  hwdata,
  input  logic               hready,
  output logic               hreadyout,
  output logic               hresp,
  output logic [DATA_W-1:0]  hrdata,
  output logic               mem_ce,
  output logic               mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);

  localparam logic [1:0] ST_OKAY = 2'd0;
  localparam logic [1:0] ST_ERR1 = 2'd1;
  localparam logic [1:0] ST_ERR2 = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              dp_valid_q, dp_valid_d;
  logic              dp_write_q, dp_write_d;
  logic [ADDR_W-1:0] dp_addr_q, dp_addr_d;
  logic [NB-1:0]     dp_be_q, dp_be_d;
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [NB-1:0]     buf_be_q, buf_be_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;

  logic [LB-1:0]     ap_lane;
  logic [ADDR_W-1:0] ap_addr;
  logic [NB-1:0]     ap_be;
  logic              ap_req, ap_valid, ap_illegal;
  logic              conflict, rd_issue, drain, wr_end, rd_dp, fwd_hit;
  logic              unused_bits;

  assign unused_bits = ^{haddr[HADDR_W-1:LB+ADDR_W], htrans[0]};

  always_comb begin
    ap_lane    = haddr[LB-1:0];
    ap_addr    = haddr[LB+ADDR_W-1:LB];
    ap_illegal = (32'(hsize) > LB) ||
                 ((32'(ap_lane) & ((32'd1 << hsize) - 32'd1)) != 32'd0);
    ap_be      = '0;
    for (int i = 0; i < NB; i++) begin
      ap_be[i] = (i >= int'(ap_lane)) && (i < int'(ap_lane) + (1 << hsize));
    end
    ap_req   = hsel & htrans[1];
    ap_valid = ap_req & hready;
    // A read arriving while a write must enter the full buffer: drain first, stall one cycle.
    conflict  = buf_valid_q & dp_valid_q & dp_write_q & ap_req & ~hwrite & ~ap_illegal;
    hreadyout = (state_q != ST_ERR1) & ~conflict;
    hresp     = (state_q != ST_OKAY);
    rd_issue  = ap_valid & ~ap_illegal & ~hwrite & ~conflict;
    drain     = buf_valid_q & ~rd_issue;
    wr_end    = dp_valid_q & dp_write_q & hreadyout;
    rd_dp     = dp_valid_q & ~dp_write_q;
    fwd_hit   = buf_valid_q & (buf_addr_q == dp_addr_q);
  end

  always_comb begin
    state_d    = state_q;
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_addr_d  = dp_addr_q;
    dp_be_d    = dp_be_q;
    if (hready) begin
      dp_valid_d = ap_valid & ~ap_illegal;
      dp_write_d = hwrite;
      dp_addr_d  = ap_addr;
      dp_be_d    = ap_be;
    end
    case (state_q)
      ST_OKAY: if (ap_valid && ap_illegal) state_d = ST_ERR1;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = (ap_valid && ap_illegal) ? ST_ERR1 : ST_OKAY;
      default: state_d = ST_OKAY;
    endcase
  end

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_be_d    = buf_be_q;
    buf_data_d  = buf_data_q;
    if (wr_end) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = dp_addr_q;
      buf_be_d    = dp_be_q;
      buf_data_d  = hwdata;
    end else if (drain) begin
      buf_valid_d = 1'b0;
    end
  end

  always_comb begin
    hrdata = '0;
    if (rd_dp) begin
      for (int i = 0; i < NB; i++) begin
        hrdata[8*i +: 8] = (fwd_hit && buf_be_q[i]) ? buf_data_q[8*i +: 8] : mem_rdata[8*i +: 8];
      end
    end
  end

  assign mem_ce    = rd_issue | drain;
  assign mem_we    = drain;
  assign mem_be    = rd_issue ? ap_be : (drain ? buf_be_q : '0);
  assign mem_addr  = rd_issue ? ap_addr : buf_addr_q;
  assign mem_wdata = buf_data_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_OKAY;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_addr_q   <= '0;
      dp_be_q     <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_be_q    <= '0;
      buf_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_addr_q   <= dp_addr_d;
      dp_be_q     <= dp_be_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_be_q    <= buf_be_d;
      buf_data_q  <= buf_data_d;
    end
  end

endmodule

// File: tb/tb_ahbl_sram_bridge.sv
// tb/tb_ahbl_sram_bridge.sv - directed bench for ahbl_sram_bridge (32-bit and 64-bit builds)
module tb_ahbl_sram_bridge;

  logic        clk = 1'b0;
  logic        rstn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready, hreadyout, hresp;
  logic [31:0] hrdata;
  logic        mem_ce, mem_we;
  logic [3:0]  mem_be;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        w_hsel;
  logic [31:0] w_haddr;
  logic [1:0]  w_htrans;
  logic        w_hwrite;
  logic [2:0]  w_hsize;
  logic [63:0] w_hwdata;
  logic        w_hready, w_hreadyout, w_hresp;
  logic [63:0] w_hrdata;
  logic        w_mem_ce, w_mem_we;
  logic [7:0]  w_mem_be;
  logic [7:0]  w_mem_addr;
  logic [63:0] w_mem_wdata;
  logic [63:0] w_mem_rdata;

  logic [31:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr;
  logic [31:0] pl_data;

  int tests = 0;
  int fails = 0;
  int stalls;

  always #5 clk = ~clk;

  assign hready      = hreadyout;
  assign w_hready    = w_hreadyout;
  assign w_mem_rdata = 64'h0;

  ahbl_sram_bridge #(.DATA_W(32), .ADDR_W(10), .HADDR_W(32)) u_dut (
    .clk(clk), .rstn(rstn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  ahbl_sram_bridge #(.DATA_W(64), .ADDR_W(8), .HADDR_W(32)) u_dut64 (
    .clk(clk), .rstn(rstn), .hsel(w_hsel), .haddr(w_haddr), .htrans(w_htrans),
    .hwrite(w_hwrite), .hsize(w_hsize), .hwdata(w_hwdata), .hready(w_hready),
    .hreadyout(w_hreadyout), .hresp(w_hresp), .hrdata(w_hrdata),
    .mem_ce(w_mem_ce), .mem_we(w_mem_we), .mem_be(w_mem_be), .mem_addr(w_mem_addr),
    .mem_wdata(w_mem_wdata), .mem_rdata(w_mem_rdata)
  );

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (mem_ce) begin
      if (mem_we) begin
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic [2:0]  size;
    logic [31:0] addr;
    logic        exp_ce;
    logic [3:0]  exp_be;
    logic [9:0]  exp_addr;
    logic        exp_err;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic ap(input logic sel, input logic [1:0] tr, input logic wr,
                    input logic [2:0] sz, input logic [31:0] a);
    hsel = sel; htrans = tr; hwrite = wr; hsize = sz; haddr = a;
  endtask

  task automatic ap64(input logic [1:0] tr, input logic [2:0] sz, input logic [31:0] a);
    w_hsel = tr[1]; w_htrans = tr; w_hwrite = 1'b0; w_hsize = sz; w_haddr = a;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    step();
    pl_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 2'd2, 3'd2, 32'h0000_000C, 1'b1, 4'hF, 10'h003, 1'b0};
    vecs[1]  = '{1'b1, 2'd2, 3'd0, 32'h0000_000D, 1'b1, 4'h2, 10'h003, 1'b0};
    vecs[2]  = '{1'b1, 2'd2, 3'd1, 32'h0000_000E, 1'b1, 4'hC, 10'h003, 1'b0};
    vecs[3]  = '{1'b1, 2'd2, 3'd0, 32'h0000_000F, 1'b1, 4'h8, 10'h003, 1'b0};
    vecs[4]  = '{1'b1, 2'd2, 3'd1, 32'h0000_000D, 1'b0, 4'h0, 10'h000, 1'b1};
    vecs[5]  = '{1'b1, 2'd2, 3'd2, 32'h0000_000E, 1'b0, 4'h0, 10'h000, 1'b1};
    vecs[6]  = '{1'b1, 2'd2, 3'd3, 32'h0000_0010, 1'b0, 4'h0, 10'h000, 1'b1};
    vecs[7]  = '{1'b1, 2'd1, 3'd2, 32'h0000_0010, 1'b0, 4'h0, 10'h000, 1'b0};
    vecs[8]  = '{1'b0, 2'd2, 3'd2, 32'h0000_0010, 1'b0, 4'h0, 10'h000, 1'b0};
    vecs[9]  = '{1'b1, 2'd2, 3'd2, 32'hFFFF_F010, 1'b1, 4'hF, 10'h004, 1'b0};
    vecs[10] = '{1'b1, 2'd0, 3'd1, 32'h0000_0001, 1'b0, 4'h0, 10'h000, 1'b0};

    rstn = 1'b0;
    ap(0, 2'd0, 0, 3'd0, 32'h0);
    ap64(2'd0, 3'd0, 32'h0);
    w_hwdata = 64'h0;
    hwdata = 32'h0;
    pl_addr = '0;
    pl_data = '0;
    step(); step();
    smp();
    chk("rst_hreadyout", hreadyout, 1'b1);
    chk("rst_hresp", hresp, 1'b0);
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_mem_ce", mem_ce, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_be", mem_be, 4'h0);
    step();
    rstn = 1'b1;

    for (int k = 0; k < 11; k++) begin
      step();
      ap(vecs[k].sel, vecs[k].trans, 1'b0, vecs[k].size, vecs[k].addr);
      smp();
      chk($sformatf("vec%0d_ce", k), mem_ce, vecs[k].exp_ce);
      chk($sformatf("vec%0d_we", k), mem_we, 1'b0);
      chk($sformatf("vec%0d_be", k), mem_be, vecs[k].exp_be);
      if (vecs[k].exp_ce) chk($sformatf("vec%0d_addr", k), mem_addr, vecs[k].exp_addr);
      step();
      ap(0, 2'd0, 0, 3'd0, 32'h0);
      smp();
      chk($sformatf("vec%0d_hresp", k), hresp, vecs[k].exp_err);
      chk($sformatf("vec%0d_hreadyout", k), hreadyout, !vecs[k].exp_err);
      if (vecs[k].exp_err) begin
        step();
        smp();
        chk($sformatf("vec%0d_err2", k), {hreadyout, hresp}, 2'b11);
      end
    end

    // Word write, two idle cycles, read back.
    step();
    ap(1, 2'd2, 1, 3'd2, 32'h100);
    smp();
    chk("t1_aphase_ce", mem_ce, 1'b0);
    step();
    ap(0, 2'd0, 0, 3'd0, 32'h0);
    hwdata = 32'hA1B2_C3D4;
    smp();
    chk("t1_dphase_ready", hreadyout, 1'b1);
    step();
    smp();
    chk("t1_drain_we", {mem_ce, mem_we}, 2'b11);
    chk("t1_drain_be", mem_be, 4'hF);
    chk("t1_drain_addr", mem_addr, 10'h040);
    chk("t1_drain_wdata", mem_wdata, 32'hA1B2_C3D4);
    step();
    smp();
    chk("t1_idle_ce", mem_ce, 1'b0);
    step();
    ap(1, 2'd2, 0, 3'd2, 32'h100);
    smp();
    chk("t1_rd_ce", {mem_ce, mem_we}, 2'b10);
    chk("t1_rd_addr", mem_addr, 10'h040);
    step();
    ap(0, 2'd0, 0, 3'd0, 32'h0);
    smp();
    chk("t1_hrdata", hrdata, 32'hA1B2_C3D4);
    chk("t1_rd_ready", hreadyout, 1'b1);

    // Byte write then immediate read: lane 3 forwarded from the buffer.
    step();
    preload(10'h040, 32'h1122_3344);
    preload(10'h002, 32'hCAFE_F00D);
    ap(1, 2'd2, 1, 3'd0, 32'h103);
    step();
    ap(1, 2'd2, 0, 3'd2, 32'h100);
    hwdata = 32'h5500_0000;
    smp();
    chk("t2_rd_ce", {mem_ce, mem_we}, 2'b10);
    chk("t2_ready", hreadyout, 1'b1);
    step();
    ap(0, 2'd0, 0, 3'd0, 32'h0);
    smp();
    chk("t2_fwd_hrdata", hrdata, 32'h5522_3344);
    chk("t2_drain_we", mem_we, 1'b1);
    chk("t2_drain_be", mem_be, 4'h8);
    step();
    ap(1, 2'd2, 0, 3'd2, 32'h100);
    step();
    ap(0, 2'd0, 0, 3'd0, 32'h0);
    smp();
    chk("t2_readback", hrdata, 32'h5522_3344);

    // Two writes then a read: exactly one stall while the first write drains.
    stalls = 0;
    step();
    ap(1, 2'd2, 1, 3'd2, 32'h0);
    smp();
    if (!hreadyout) stalls++;
    step();
    ap(1, 2'd2, 1, 3'd2, 32'h4);
    hwdata = 32'h1;
    smp();
    if (!hreadyout) stalls++;
    chk("t3_w2_ce", mem_ce, 1'b0);
    step();
    ap(1, 2'd2, 0, 3'd2, 32'h8);
    hwdata = 32'h2;
    smp();
    if (!hreadyout) stalls++;
    chk("t3_stall", hreadyout, 1'b0);
    chk("t3_drain0", {mem_ce, mem_we, mem_addr}, {2'b11, 10'h000});
    chk("t3_drain0_data", mem_wdata, 32'h1);
    step();
    smp();
    if (!hreadyout) stalls++;
    chk("t3_rd_issue", {hreadyout, mem_ce, mem_we, mem_addr}, {3'b110, 10'h002});
    step();
    ap(0, 2'd0, 0, 3'd0, 32'h0);
    smp();
    if (!hreadyout) stalls++;
    chk("t3_hrdata", hrdata, 32'hCAFE_F00D);
    chk("t3_drain1", {mem_we, mem_addr}, {1'b1, 10'h001});
    chk("t3_drain1_data", mem_wdata, 32'h2);
    step();
    smp();
    chk("t3_idle_ce", mem_ce, 1'b0);
    chk("t3_stall_count", stalls, 1);

    // Misaligned halfword write: two-cycle ERROR, no SRAM access.
    step();
    ap(1, 2'd2, 1, 3'd1, 32'h101);
    smp();
    chk("t4_ap_ce", mem_ce, 1'b0);
    step();
    ap(0, 2'd0, 0, 3'd0, 32'h0);
    smp();
    chk("t4_err1", {hreadyout, hresp, mem_ce}, 3'b010);
    step();
    smp();
    chk("t4_err2", {hreadyout, hresp, mem_ce}, 3'b110);
    step();
    smp();
    chk("t4_okay", {hreadyout, hresp}, 2'b10);
    step();
    ap(1, 2'd2, 0, 3'd2, 32'h102);
    step();
    ap(0, 2'd0, 0, 3'd0, 32'h0);
    smp();
    chk("t4b_err1", {hreadyout, hresp}, 2'b01);
    step();
    ap(1, 2'd2, 0, 3'd2, 32'h8);
    smp();
    chk("t4b_err2_accept", {hreadyout, hresp, mem_ce, mem_addr}, {3'b111, 10'h002});
    step();
    ap(0, 2'd0, 0, 3'd0, 32'h0);
    smp();
    chk("t4b_after", {hreadyout, hresp}, 2'b10);
    chk("t4b_hrdata", hrdata, 32'hCAFE_F00D);

    // 64-bit build: lanes, top word, hsize limits.
    step();
    ap64(2'd2, 3'd2, 32'h7FC);
    smp();
    chk("w_rd_ce", w_mem_ce, 1'b1);
    chk("w_rd_addr", w_mem_addr, 8'hFF);
    chk("w_rd_be", w_mem_be, 8'hF0);
    step();
    ap64(2'd2, 3'd3, 32'h7F8);
    smp();
    chk("w_rd_hresp", w_hresp, 1'b0);
    chk("w_dw_ce_be", {w_mem_ce, w_mem_be}, {1'b1, 8'hFF});
    step();
    ap64(2'd2, 3'd4, 32'h7F0);
    smp();
    chk("w_dw_hresp", w_hresp, 1'b0);
    chk("w_big_ce", w_mem_ce, 1'b0);
    step();
    ap64(2'd0, 3'd0, 32'h0);
    smp();
    chk("w_err1", {w_hreadyout, w_hresp}, 2'b01);
    step();
    smp();
    chk("w_err2", {w_hreadyout, w_hresp}, 2'b11);
    chk("w_quiet", {w_mem_we, w_hrdata, w_mem_wdata}, 129'h0);

    // Reset while the buffer holds an undrained write.
    step();
    preload(10'h080, 32'h0BAD_F00D);
    ap(1, 2'd2, 1, 3'd2, 32'h200);
    step();
    ap(0, 2'd0, 0, 3'd0, 32'h0);
    hwdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("t6_rst_ready", {hreadyout, hresp}, 2'b10);
    chk("t6_rst_mem", {mem_ce, mem_we, mem_be}, 6'h0);
    chk("t6_rst_hrdata", hrdata, 32'h0);
    step();
    rstn = 1'b1;
    step();
    ap(1, 2'd2, 0, 3'd2, 32'h200);
    step();
    ap(0, 2'd0, 0, 3'd0, 32'h0);
    smp();
    chk("t6_old_data", hrdata, 32'h0BAD_F00D);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
